// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the adder operand sequencer: FSM state
// encoding, beat-count helper and status-beat bit positions.
package adder_seq_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_A = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_LOAD_C = 3'd2,
    ST_SETTLE = 3'd3,
    ST_EMIT_S = 3'd4,
    ST_EMIT_F = 3'd5
  } seq_state_e;

  localparam int CF_BIT  = 0;
  localparam int OVF_BIT = 1;

  // Number of bus beats needed to carry one full-width operand.
  function automatic int beats_f(input int data_width, input int bus_width);
    return data_width / bus_width;
  endfunction

endpackage

// File: rtl/adder_operand_sequencer_seq_counter.sv
// Loadable down-counter with a zero flag; used as the beat counter and as
// the settle counter of the adder operand sequencer.
module seq_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/adder_operand_sequencer.sv
// Narrow-stream front end for a full-width combinational adder: loads A, B,
// Cin beat by beat, waits a settle window, then streams S and a status beat.
// Optional macro ADDER_SEQ_OVF_EN adds a signed-overflow flag on status bit1.
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int BUS_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BUS_WIDTH-1:0]  in_data,
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  output logic                  add_cin,
  input  logic [DATA_WIDTH-1:0] add_s,
  input  logic                  add_cf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BUS_WIDTH-1:0]  out_data,
  output logic                  out_last
);

  localparam int BEATS = beats_f(DATA_WIDTH, BUS_WIDTH);
  localparam int BCW   = $clog2(BEATS + 1);
  localparam int SCW   = $clog2(SETTLE_CYCLES + 1);
  localparam int MSB   = DATA_WIDTH - 1;

  seq_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic                  cin_q, cin_d, cf_q, cf_d;
`ifdef ADDER_SEQ_OVF_EN
  logic                  ovf_q, ovf_d;
`endif

  logic           in_fire, out_fire;
  logic           b_load, b_dec, b_zero;
  logic [BCW-1:0] b_load_val, b_cnt, idx;
  logic           beat_last, beat_adv;
  logic           s_load, s_dec, s_zero;
  logic [SCW-1:0] s_load_val, s_cnt;

  seq_counter #(.W(BCW)) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (b_load),
    .load_val_i (b_load_val),
    .dec_i      (b_dec),
    .count_o    (b_cnt),
    .zero_o     (b_zero)
  );

  seq_counter #(.W(SCW)) u_settle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (s_load),
    .load_val_i (s_load_val),
    .dec_i      (s_dec),
    .count_o    (s_cnt),
    .zero_o     (s_zero)
  );

  // Beat counter idles at zero for slice 0, then counts down from BEATS-1
  // so that slice index k = BEATS - count for the remaining beats.
  assign idx       = b_zero ? '0 : (BCW'(BEATS) - b_cnt);
  assign beat_last = (idx == BCW'(BEATS - 1));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    b_load     = 1'b0;
    b_load_val = '0;
    b_dec      = 1'b0;
    if (beat_adv) begin
      if (beat_last) begin
        b_load = 1'b1;
      end else if (b_zero) begin
        b_load     = 1'b1;
        b_load_val = BCW'(BEATS - 1);
      end else begin
        b_dec = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    res_d      = res_q;
    cf_d       = cf_q;
`ifdef ADDER_SEQ_OVF_EN
    ovf_d      = ovf_q;
`endif
    beat_adv   = 1'b0;
    s_load     = 1'b0;
    s_load_val = '0;
    s_dec      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    case (state_q)
      ST_LOAD_A: begin
        in_ready = 1'b1;
        if (in_fire) begin
          a_d[idx*BUS_WIDTH +: BUS_WIDTH] = in_data;
          beat_adv = 1'b1;
          if (beat_last) state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        in_ready = 1'b1;
        if (in_fire) begin
          b_d[idx*BUS_WIDTH +: BUS_WIDTH] = in_data;
          beat_adv = 1'b1;
          if (beat_last) state_d = ST_LOAD_C;
        end
      end
      ST_LOAD_C: begin
        in_ready = 1'b1;
        if (in_fire) begin
          cin_d      = in_data[0];
          s_load     = 1'b1;
          s_load_val = SCW'(SETTLE_CYCLES - 1);
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // The last of SETTLE_CYCLES edges samples the adder outputs.
        s_dec = (s_cnt != '0);
        if (s_zero) begin
          res_d   = add_s;
          cf_d    = add_cf;
`ifdef ADDER_SEQ_OVF_EN
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (add_s[MSB] != a_q[MSB]);
`endif
          state_d = ST_EMIT_S;
        end
      end
      ST_EMIT_S: begin
        out_valid = 1'b1;
        out_data  = res_q[idx*BUS_WIDTH +: BUS_WIDTH];
        if (out_fire) begin
          beat_adv = 1'b1;
          if (beat_last) state_d = ST_EMIT_F;
        end
      end
      ST_EMIT_F: begin
        out_valid        = 1'b1;
        out_last         = 1'b1;
        out_data[CF_BIT] = cf_q;
`ifdef ADDER_SEQ_OVF_EN
        out_data[OVF_BIT] = ovf_q;
`endif
        if (out_fire) state_d = ST_LOAD_A;
      end
      default: state_d = ST_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      cf_q    <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      cf_q    <= cf_d;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign add_a   = a_q;
  assign add_b   = b_q;
  assign add_cin = cin_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer with a behavioural adder attached.
module tb_adder_operand_sequencer;

  localparam int DW = 16;
  localparam int BW = 8;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic [DW-1:0] add_a, add_b, add_s;
  logic          add_cin, add_cf;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic [DW:0]   sum;

  int checks = 0;
  int errors = 0;
  logic [7:0] ovf_status;

  adder_operand_sequencer #(
    .DATA_WIDTH    (DW),
    .BUS_WIDTH     (BW),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cf    (add_cf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  assign sum    = (DW+1)'(add_a) + (DW+1)'(add_b) + (DW+1)'(add_cin);
  assign add_s  = sum[DW-1:0];
  assign add_cf = sum[DW];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic recv(input logic [7:0] ed, input logic el, input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(ed));
    check({tag, "_last"}, 32'(out_last), 32'(el));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] est,
                         input string tag);
    send(a[7:0], tag);
    send(a[15:8], tag);
    send(b[7:0], tag);
    send(b[15:8], tag);
    send({7'b0, cin}, tag);
    recv(e0, 1'b0, {tag, "_s0"});
    recv(e1, 1'b0, {tag, "_s1"});
    recv(est, 1'b1, {tag, "_st"});
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
`ifdef ADDER_SEQ_OVF_EN
    ovf_status = 8'h02;
`else
    ovf_status = 8'h00;
`endif
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_add_cin", 32'(add_cin), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0x1234 + 0x0001 with settle-latency probing around the control beat
    send(8'h34, "t1");
    send(8'h12, "t1");
    send(8'h01, "t1");
    send(8'h00, "t1");
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("t1_add_a", 32'(add_a), 32'h1234);
    check("t1_add_b", 32'(add_b), 32'h0001);
    check("t1_add_cin", 32'(add_cin), 32'd0);
    check("t1_e0_ready", 32'(in_ready), 32'd0);
    check("t1_e0_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_e1_ready", 32'(in_ready), 32'd0);
    check("t1_e1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_e2_valid", 32'(out_valid), 32'd1);
    check("t1_e2_ready", 32'(in_ready), 32'd0);
    recv(8'h35, 1'b0, "t1_s0");
    recv(8'h12, 1'b0, "t1_s1");
    check("t1_emitf_ready", 32'(in_ready), 32'd0);
    recv(8'h00, 1'b1, "t1_st");
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    check("t1_idle_ready", 32'(in_ready), 32'd1);

    // Carry out
    run_txn(16'hFFFF, 16'h0001, 1'b0, 8'h00, 8'h00, 8'h01, "t2");

    // Signed overflow
    run_txn(16'h7FFF, 16'h0001, 1'b0, 8'h00, 8'h80, ovf_status, "t3");

    // Carry in, plus a 5-cycle stall mid-EMIT_S with ignored input pulses
    send(8'hFF, "t4");
    send(8'hFF, "t4");
    send(8'h01, "t4");
    send(8'h00, "t4");
    send(8'h01, "t4");
    recv(8'h01, 1'b0, "t4_s0");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA5;
      @(negedge clk);
      check("t4_stall_valid", 32'(out_valid), 32'd1);
      check("t4_stall_data", 32'(out_data), 32'h00);
      check("t4_stall_last", 32'(out_last), 32'd0);
      check("t4_stall_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    in_data  = '0;
    check("t4_hold_a", 32'(add_a), 32'hFFFF);
    check("t4_hold_b", 32'(add_b), 32'h0001);
    recv(8'h00, 1'b0, "t4_s1");
    recv(8'h01, 1'b1, "t4_st");

    // Abort after two A beats
    send(8'hAA, "t5");
    send(8'hBB, "t5");
    check("t5_partial_a", 32'(add_a), 32'hBBAA);
    rst = 1'b1;
    #1;
    check("t5_rst_a", 32'(add_a), 32'd0);
    check("t5_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(16'h0010, 16'h0020, 1'b1, 8'h31, 8'h00, 8'h00, "t6");
    check("t6_add_a", 32'(add_a), 32'h0010);
    check("t6_add_b", 32'(add_b), 32'h0020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
